// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and default widths for the scratch-SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_default_addr_w = 6;
    localparam int c_default_data_w = 8;

    // Arbiter sequence: pick a requester, drive the macro, return the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker with optional port-0
//               priority. Search starts one past the last-served port.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             prio,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    // Rotating search; with prio set, port 0 is taken first and then excluded
    // from the rotation so the remaining ports share the leftover slots.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        if (prio && req[0]) begin
            grant[0] = 1'b1;
            valid    = 1'b1;
        end
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!valid && req[idx] && !(prio && (idx == 0))) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_sram_arbiter
// Description : Serialises accesses from N_REQ requesters onto a single-port
//               scratch SRAM macro using a 3-cycle IDLE/ACCESS/RESP sequence
//               and a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DATA_W     = c_default_data_w,
    parameter int PRIO_PORT0 = 0
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_din,
    output logic                     sram_cen_n,
    output logic                     sram_gwe_n,
    input  logic [DATA_W-1:0]        sram_dout
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_idx_w-1:0]   r_gnt_idx;
    logic [c_idx_w-1:0]   r_ptr;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;

    logic [N_REQ-1:0]     w_pick_grant;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_picker (
        .req       (req),
        .ptr       (r_ptr),
        .prio      (PRIO_PORT0 != 0),
        .grant     (w_pick_grant),
        .grant_idx (w_pick_idx),
        .valid     (w_pick_valid)
    );

    // One-hot AND-OR select of the winning requester's command fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register; an async reset drops straight to IDLE so the macro
    // strobes (decoded from state) release immediately.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the granted command in IDLE, advance the pointer and capture
    // read data as the access completes.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_idx <= '0;
            r_ptr     <= c_idx_w'(N_REQ - 1);
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            if ((r_state == IDLE) && w_pick_valid) begin
                r_gnt_idx <= w_pick_idx;
                r_we      <= w_sel_we;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
            end
            if (r_state == RESP) begin
                r_ptr <= r_gnt_idx;
                if (!r_we) begin
                    r_rdata <= sram_dout;
                end
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        ack          = '0;
        sram_cen_n   = 1'b1;
        sram_gwe_n   = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                sram_cen_n   = 1'b0;
                sram_gwe_n   = !r_we;
                w_next_state = RESP;
            end
            RESP: begin
                for (int i = 0; i < N_REQ; i++) begin
                    ack[i] = (r_gnt_idx == c_idx_w'(i));
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Read data is passed through in the ack cycle and held afterwards.
    assign rdata     = ((r_state == RESP) && !r_we) ? sram_dout : r_rdata;
    assign busy      = (r_state != IDLE);
    assign sram_addr = r_addr;
    assign sram_din  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_shared_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_sram_arbiter
// Description : Directed self-checking bench for shared_sram_arbiter with a
//               round-robin instance and a port-0-priority instance, each
//               attached to a small behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // round-robin instance
    logic [2:0]  req = '0, we = '0;
    logic [17:0] addr = '0;
    logic [23:0] wdata = '0;
    logic [2:0]  ack;
    logic [7:0]  rdata, sram_din, sram_dout;
    logic        busy, sram_cen_n, sram_gwe_n;
    logic [5:0]  sram_addr;

    // port-0-priority instance
    logic [2:0]  req_p = '0, we_p = '0;
    logic [17:0] addr_p = '0;
    logic [23:0] wdata_p = '0;
    logic [2:0]  ack_p;
    logic [7:0]  rdata_p, sram_din_p, sram_dout_p;
    logic        busy_p, sram_cen_n_p, sram_gwe_n_p;
    logic [5:0]  sram_addr_p;

    logic [7:0]  mem   [64];
    logic [7:0]  mem_p [64];
    logic        mem_ready = 1'b0;
    int          cen_cnt = 0;

    always #5 clk = ~clk;

    shared_sram_arbiter #(.N_REQ(3), .ADDR_W(6), .DATA_W(8), .PRIO_PORT0(0)) dut (
        .wb_clk_i(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_cen_n(sram_cen_n),
        .sram_gwe_n(sram_gwe_n), .sram_dout(sram_dout)
    );

    shared_sram_arbiter #(.N_REQ(3), .ADDR_W(6), .DATA_W(8), .PRIO_PORT0(1)) dut_p (
        .wb_clk_i(clk), .rst_n(rst_n), .req(req_p), .we(we_p), .addr(addr_p),
        .wdata(wdata_p), .ack(ack_p), .rdata(rdata_p), .busy(busy_p),
        .sram_addr(sram_addr_p), .sram_din(sram_din_p), .sram_cen_n(sram_cen_n_p),
        .sram_gwe_n(sram_gwe_n_p), .sram_dout(sram_dout_p)
    );

    // Behavioural macros: contents preset to addr^0xA5, read data one cycle
    // after enable.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]   <= 8'(i) ^ 8'hA5;
                mem_p[i] <= 8'(i) ^ 8'hA5;
            end
            mem_ready <= 1'b1;
        end else begin
            if (!sram_cen_n) begin
                cen_cnt <= cen_cnt + 1;
                if (!sram_gwe_n) mem[sram_addr] <= sram_din;
                else             sram_dout <= mem[sram_addr];
            end
            if (!sram_cen_n_p) begin
                if (!sram_gwe_n_p) mem_p[sram_addr_p] <= sram_din_p;
                else               sram_dout_p <= mem_p[sram_addr_p];
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; we = '0; req_p = '0; we_p = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 3'b000 || rdata !== 8'h00 || busy !== 1'b0 || sram_addr !== 6'h00 ||
            sram_din !== 8'h00 || sram_cen_n !== 1'b1 || sram_gwe_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ack=%b rdata=%h busy=%b addr=%h din=%h cen_n=%b gwe_n=%b, required 000 00 0 00 00 1 1",
                     ack, rdata, busy, sram_addr, sram_din, sram_cen_n, sram_gwe_n);
        end
        checks++;
        if (ack_p !== 3'b000 || busy_p !== 1'b0 || sram_cen_n_p !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_prio: ack=%b busy=%b cen_n=%b, required 000 0 1", ack_p, busy_p, sram_cen_n_p);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req = 3'b010; we = 3'b010; addr[6 +: 6] = 6'h2A; wdata[8 +: 8] = 8'h5C;
        @(negedge clk);
        checks++;
        if (sram_cen_n !== 1'b0 || sram_gwe_n !== 1'b0 || sram_addr !== 6'h2A || sram_din !== 8'h5C ||
            busy !== 1'b1 || ack !== 3'b000) begin
            errors++;
            $display("FAIL write_access: cen_n=%b gwe_n=%b addr=%h din=%h busy=%b ack=%b, required 0 0 2a 5c 1 000",
                     sram_cen_n, sram_gwe_n, sram_addr, sram_din, busy, ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 3'b010) begin
            errors++;
            $display("FAIL write_ack: ack=%b, required 010", ack);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 3'b000 || sram_cen_n !== 1'b1) begin
            errors++;
            $display("FAIL write_idle: busy=%b ack=%b cen_n=%b, required 0 000 1", busy, ack, sram_cen_n);
        end
        req = 3'b010; we = 3'b000;
        @(negedge clk);
        checks++;
        if (sram_cen_n !== 1'b0 || sram_gwe_n !== 1'b1 || sram_addr !== 6'h2A) begin
            errors++;
            $display("FAIL read_access: cen_n=%b gwe_n=%b addr=%h, required 0 1 2a", sram_cen_n, sram_gwe_n, sram_addr);
        end
        @(negedge clk);
        checks++;
        if (ack !== 3'b010 || rdata !== 8'h5C) begin
            errors++;
            $display("FAIL read_ack: ack=%b rdata=%h, required 010 5c", ack, rdata);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (rdata !== 8'h5C) begin
            errors++;
            $display("FAIL read_hold: rdata=%h, required 5c", rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack;
        logic [7:0] exp_rd;
        int         slot;
        test_reset();
        @(negedge clk);
        req = 3'b111; we = 3'b000;
        addr = {6'h03, 6'h02, 6'h01};
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            exp_ack = 3'b000;
            exp_rd  = 8'h00;
            if (c % 3 == 2) begin
                slot    = ((c - 2) / 3) % 3;
                exp_ack = 3'b001 << slot;
                exp_rd  = 8'(slot + 1) ^ 8'hA5;
            end
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL rr_ack_c%0d: ack=%b, required %b", c, ack, exp_ack);
            end
            if (exp_ack != 3'b000) begin
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL rr_rdata_c%0d: rdata=%h, required %h", c, rdata, exp_rd);
                end
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_prio_port0();
        @(negedge clk);
        req_p = 3'b101; we_p = 3'b000;
        for (int s = 0; s < 3; s++) begin
            repeat ((s == 0) ? 2 : 3) @(negedge clk);
            checks++;
            if (ack_p !== 3'b001) begin
                errors++;
                $display("FAIL prio_slot%0d: ack=%b, required 001", s, ack_p);
            end
        end
        req_p = 3'b100;
        repeat (3) @(negedge clk);
        checks++;
        if (ack_p !== 3'b100) begin
            errors++;
            $display("FAIL prio_release: ack=%b, required 100", ack_p);
        end
        req_p = '0;
        @(negedge clk);
    endtask

    task automatic test_short_pulse();
        int cnt0;
        @(negedge clk);
        cnt0 = cen_cnt;
        req = 3'b001; we = 3'b001; addr[0 +: 6] = 6'h05; wdata[0 +: 8] = 8'h11;
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 3'b001) begin
            errors++;
            $display("FAIL pulse_owner_ack: ack=%b, required 001", ack);
        end
        req = '0; we = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL pulse_no_grant_c%0d: ack=%b busy=%b, required 000 0", c, ack, busy);
            end
        end
        checks++;
        if (cen_cnt - cnt0 !== 1) begin
            errors++;
            $display("FAIL pulse_access_count: enables=%0d, required 1", cen_cnt - cnt0);
        end
    endtask

    task automatic test_input_change();
        @(negedge clk);
        req = 3'b010; we = 3'b010; addr[6 +: 6] = 6'h10; wdata[8 +: 8] = 8'h77;
        @(negedge clk);
        addr[6 +: 6] = 6'h3F; wdata[8 +: 8] = 8'hEE;
        checks++;
        if (sram_addr !== 6'h10 || sram_din !== 8'h77 || sram_gwe_n !== 1'b0) begin
            errors++;
            $display("FAIL change_latched: addr=%h din=%h gwe_n=%b, required 10 77 0", sram_addr, sram_din, sram_gwe_n);
        end
        @(negedge clk);
        checks++;
        if (ack !== 3'b010) begin
            errors++;
            $display("FAIL change_ack: ack=%b, required 010", ack);
        end
        req = '0; we = '0;
        @(negedge clk);
        checks++;
        if (mem[6'h10] !== 8'h77 || mem[6'h3F] !== 8'h9A) begin
            errors++;
            $display("FAIL change_mem: mem10=%h mem3f=%h, required 77 9a", mem[6'h10], mem[6'h3F]);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req = 3'b010; we = 3'b000; addr[6 +: 6] = 6'h03;
        @(negedge clk);
        checks++;
        if (sram_cen_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_access: cen_n=%b, required 0", sram_cen_n);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (sram_cen_n !== 1'b1 || sram_gwe_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: cen_n=%b gwe_n=%b busy=%b, required 1 1 0", sram_cen_n, sram_gwe_n, busy);
        end
        @(negedge clk);
        checks++;
        if (ack !== 3'b000) begin
            errors++;
            $display("FAIL rst_no_ack: ack=%b, required 000", ack);
        end
        rst_n = 1'b1;
        req = 3'b111; we = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 3'b001) begin
            errors++;
            $display("FAIL rst_first_grant: ack=%b, required 001", ack);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_prio_port0();
        test_short_pulse();
        test_input_change();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
